// File: rtl/sopc_base_cpu_cpu_ocimem_arbiter.sv
// OCI debug RAM arbiter: shares one RAM port between JTAG command
// strobes (pointer-based, auto-increment) and the CPU debug slave port.
module sopc_base_cpu_cpu_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    input  logic [31:0]       ram_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_RDWAIT, S_WR} state_t;
    typedef enum logic [1:0] {C_LOAD_RD, C_RD_INC, C_WR_INC} cmd_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_pend;
    cmd_t              r_pcmd;
    cmd_t              r_ocmd;
    logic [31:0]       r_jwdata;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_own_jtag;
    logic              r_last_jtag;
    logic              r_overrun;
    logic [31:0]       r_mon;

    logic w_creq;
    logic w_any;
    logic w_acc;
    logic w_drop;
    logic w_grant_j;
    logic w_grant_c;
    logic w_jtag_act;
    logic w_cpu_done;
    logic w_inc;
    logic w_unused;

    assign w_creq     = cpu_read | cpu_write;
    assign w_jtag_act = (r_state != S_IDLE) & r_own_jtag;
    assign w_cpu_done = ((r_state == S_WR) | (r_state == S_RDWAIT)) & ~r_own_jtag;
    assign w_any      = take_action_ocimem_a | take_action_ocimem_b
                      | take_no_action_ocimem_a;
    assign w_acc      = w_any & ~jtag_busy;
    // Everything but the highest-priority strobe of an accepted cycle is lost.
    assign w_drop     = jtag_busy ? w_any
                      : (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                      | (take_action_ocimem_b & take_no_action_ocimem_a);
    assign w_inc      = w_jtag_act & ((r_state == S_WR)
                      | ((r_state == S_RDWAIT) & (r_ocmd == C_RD_INC)));
    assign w_unused   = ^{jdo[37:35], jdo[1:0]};

    assign jtag_busy       = r_pend | w_jtag_act;
    assign jtag_overrun    = r_overrun;
    assign MonDReg         = r_mon;
    assign cpu_waitrequest = w_creq & ~w_cpu_done;
    assign cpu_readdata    = ((r_state == S_RDWAIT) && !r_own_jtag) ? ram_rdata : '0;

    // On a tie the requester that did not own the last access wins.
    always_comb begin
        w_next    = r_state;
        w_grant_j = 1'b0;
        w_grant_c = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_pend && (!w_creq || !r_last_jtag)) begin
                    w_grant_j = 1'b1;
                    w_next    = (r_pcmd == C_WR_INC) ? S_WR : S_RD;
                end else if (w_creq) begin
                    w_grant_c = 1'b1;
                    w_next    = cpu_write ? S_WR : S_RD;
                end
            end
            S_RD:     w_next = S_RDWAIT;
            S_RDWAIT: w_next = S_IDLE;
            S_WR:     w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_we      <= 1'b0;
            ram_re      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            r_own_jtag  <= 1'b0;
            r_last_jtag <= 1'b0;
            r_ocmd      <= C_LOAD_RD;
        end else begin
            ram_we <= 1'b0;
            ram_re <= 1'b0;
            if (w_grant_j) begin
                r_own_jtag  <= 1'b1;
                r_last_jtag <= 1'b1;
                r_ocmd      <= r_pcmd;
                ram_addr    <= r_ptr;
                if (r_pcmd == C_WR_INC) begin
                    ram_we    <= 1'b1;
                    ram_wdata <= r_jwdata;
                end else begin
                    ram_re <= 1'b1;
                end
            end else if (w_grant_c) begin
                r_own_jtag  <= 1'b0;
                r_last_jtag <= 1'b0;
                ram_addr    <= cpu_address;
                if (cpu_write) begin
                    ram_we    <= 1'b1;
                    ram_wdata <= cpu_writedata;
                end else begin
                    ram_re <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend    <= 1'b0;
            r_pcmd    <= C_LOAD_RD;
            r_jwdata  <= '0;
            r_ptr     <= '0;
            r_mon     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_grant_j) begin
                r_pend <= 1'b0;
            end else if (w_acc) begin
                r_pend <= 1'b1;
                if (take_action_ocimem_a)      r_pcmd <= C_LOAD_RD;
                else if (take_action_ocimem_b) r_pcmd <= C_WR_INC;
                else                           r_pcmd <= C_RD_INC;
            end
            if (w_acc && take_action_ocimem_a) r_ptr <= jdo[ADDR_W+1:2];
            else if (w_inc)                    r_ptr <= r_ptr + ADDR_W'(1);
            if (w_acc && !take_action_ocimem_a && take_action_ocimem_b)
                r_jwdata <= jdo[34:3];
            if ((r_state == S_RDWAIT) && r_own_jtag) r_mon <= ram_rdata;
            r_overrun <= (r_overrun & ~(w_acc & take_action_ocimem_a)) | w_drop;
        end
    end

endmodule

// File: tb/tb_sopc_base_cpu_cpu_ocimem_arbiter.sv
// Self-checking bench for the OCI RAM arbiter: directed scenarios plus
// randomized traffic checked against a simple memory/pointer model.
module tb_sopc_base_cpu_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        ta, tn, tb;
    logic        cpu_read, cpu_write;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [31:0] ram_rdata;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we, ram_re;
    logic [31:0] MonDReg;
    logic        jtag_busy, jtag_overrun;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [256];
    logic [31:0] model_mem [256];
    logic [7:0]  m_ptr;
    logic [7:0]  re_q [$];

    always #5 clk = ~clk;

    sopc_base_cpu_cpu_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta),
        .take_no_action_ocimem_a(tn),
        .take_action_ocimem_b(tb),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
        .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
        .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_re(ram_re), .MonDReg(MonDReg),
        .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
    );

    // RAM macro stand-in with one cycle of read latency, plus a read log.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_addr];
        if (ram_re) re_q.push_back(ram_addr);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // kind 0 = take_action_a (load+read), 1 = no_action_a (read+inc), 2 = b (write+inc)
    task automatic jtag_strobe(input int kind, input logic [7:0] a, input logic [31:0] d);
        jdo = (kind == 0) ? {28'b0, a, 2'b0} : {3'b0, d, 3'b0};
        ta = (kind == 0);
        tn = (kind == 1);
        tb = (kind == 2);
        tick();
        ta = 1'b0;
        tn = 1'b0;
        tb = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (jtag_busy && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (jtag_busy) begin
            errors++;
            $display("FAIL %s busy_timeout: jtag_busy still 1 after %0d cycles", tag, n);
        end
    endtask

    task automatic jtag_op(input int kind, input logic [7:0] a, input logic [31:0] d);
        jtag_strobe(kind, a, d);
        wait_idle("jtag_op");
    endtask

    task automatic cpu_access(input bit wr, input logic [7:0] a, input logic [31:0] d,
                              output logic [31:0] rd, output int waits);
        cpu_write = wr;
        cpu_read = !wr;
        cpu_address = a;
        cpu_writedata = d;
        waits = 0;
        #1;
        while (cpu_waitrequest && waits < 40) begin
            waits++;
            @(posedge clk);
            #2;
        end
        rd = cpu_readdata;
        tick();
        cpu_read = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        ta = 1'b0; tn = 1'b0; tb = 1'b0; jdo = '0;
        cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_address = '0; cpu_writedata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        m_ptr = 8'h00;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({ram_we, ram_re, jtag_busy, jtag_overrun, cpu_waitrequest} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {ram_we, ram_re, jtag_busy, jtag_overrun, cpu_waitrequest});
        end
        checks++;
        if (ram_addr !== 8'h00 || ram_wdata !== 32'h0 || MonDReg !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: addr=%h wdata=%h mon=%h want 0", ram_addr, ram_wdata, MonDReg);
        end
        reset = 1'b1;
        cpu_read = 1'b1;
        #2;
        checks++;
        if (cpu_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL reset_waitreq: got %b want 1", cpu_waitrequest);
        end
        cpu_read = 1'b0;
        apply_reset();
    endtask

    task automatic test_load_read;
        logic [31:0] rd;
        int w;
        cpu_access(1'b1, 8'h10, 32'hCAFE_F00D, rd, w);
        model_mem[8'h10] = 32'hCAFE_F00D;
        jtag_strobe(0, 8'h10, 32'h0);
        checks++;
        if (jtag_busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy_s1: got %b want 1", jtag_busy);
        end
        tick();
        checks++;
        if (ram_re !== 1'b1 || ram_addr !== 8'h10) begin
            errors++;
            $display("FAIL load_re_s2: re=%b addr=%h want re=1 addr=10", ram_re, ram_addr);
        end
        tick();
        tick();
        checks++;
        if (MonDReg !== 32'hCAFE_F00D || jtag_busy !== 1'b0) begin
            errors++;
            $display("FAIL load_mon_s4: mon=%h busy=%b want cafef00d/0", MonDReg, jtag_busy);
        end
        jtag_op(1, 8'h0, 32'h0);
        checks++;
        if (re_q[$] !== 8'h10 || MonDReg !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL load_ptr_kept: addr=%h mon=%h want 10/cafef00d", re_q[$], MonDReg);
        end
    endtask

    task automatic test_write_wrap;
        logic [31:0] rd;
        int w;
        logic [7:0] exp_a;
        jtag_op(0, 8'hFE, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            exp_a = 8'(8'hFD + k);
            jtag_strobe(2, 8'h0, 32'(k));
            tick();
            checks++;
            if (ram_we !== 1'b1 || ram_addr !== exp_a || ram_wdata !== 32'(k)) begin
                errors++;
                $display("FAIL wrap_write%0d: we=%b addr=%h data=%h want 1/%h/%h",
                         k, ram_we, ram_addr, ram_wdata, exp_a, k);
            end
            model_mem[exp_a] = 32'(k);
            wait_idle("wrap");
        end
        jtag_op(1, 8'h0, 32'h0);
        checks++;
        if (re_q[$] !== 8'h01) begin
            errors++;
            $display("FAIL wrap_read_addr: got %h want 01", re_q[$]);
        end
        cpu_access(1'b0, 8'h00, 32'h0, rd, w);
        checks++;
        if (rd !== 32'd3) begin
            errors++;
            $display("FAIL wrap_data00: got %h want 3", rd);
        end
    endtask

    task automatic test_cpu_rw;
        logic [31:0] rd;
        int w;
        cpu_access(1'b1, 8'h20, 32'h1234_5678, rd, w);
        model_mem[8'h20] = 32'h1234_5678;
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL cpu_write_wait: got %0d want 1", w);
        end
        cpu_access(1'b0, 8'h20, 32'h0, rd, w);
        checks++;
        if (w != 2 || rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL cpu_read: wait=%0d data=%h want 2/12345678", w, rd);
        end
    endtask

    task automatic test_tie;
        logic [31:0] rd;
        int w;
        int base;
        apply_reset();
        base = re_q.size();
        jtag_strobe(1, 8'h0, 32'h0);
        cpu_access(1'b0, 8'h30, 32'h0, rd, w);
        wait_idle("tie1");
        checks++;
        if (w != 5 || re_q.size() != base + 2 || re_q[base] !== 8'h00 || re_q[base+1] !== 8'h30) begin
            errors++;
            $display("FAIL tie_jtag_first: wait=%0d n=%0d order=%h,%h want 5/2/00,30",
                     w, re_q.size() - base, re_q[base], re_q[base+1]);
        end
        jtag_op(1, 8'h0, 32'h0);
        base = re_q.size();
        jtag_strobe(1, 8'h0, 32'h0);
        cpu_access(1'b0, 8'h31, 32'h0, rd, w);
        wait_idle("tie2");
        checks++;
        if (w != 2 || re_q.size() != base + 2 || re_q[base] !== 8'h31 || re_q[base+1] !== 8'h02) begin
            errors++;
            $display("FAIL tie_cpu_first: wait=%0d n=%0d order=%h,%h want 2/2/31,02",
                     w, re_q.size() - base, re_q[base], re_q[base+1]);
        end
    endtask

    task automatic test_overrun;
        int base;
        base = re_q.size();
        jtag_strobe(0, 8'h40, 32'h0);
        tick();
        tn = 1'b1;
        tick();
        tn = 1'b0;
        checks++;
        if (jtag_overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b want 1", jtag_overrun);
        end
        wait_idle("ovr");
        repeat (4) tick();
        checks++;
        if (re_q.size() != base + 1 || re_q[$] !== 8'h40) begin
            errors++;
            $display("FAIL overrun_dropped: reads=%0d last=%h want 1/40", re_q.size() - base, re_q[$]);
        end
        jtag_strobe(0, 8'h10, 32'h0);
        checks++;
        if (jtag_overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b want 0", jtag_overrun);
        end
        wait_idle("ovr2");
        base = re_q.size();
        jdo = {28'b0, 8'h50, 2'b0};
        ta = 1'b1;
        tb = 1'b1;
        tick();
        ta = 1'b0;
        tb = 1'b0;
        checks++;
        if (jtag_overrun !== 1'b1) begin
            errors++;
            $display("FAIL prio_overrun: got %b want 1", jtag_overrun);
        end
        wait_idle("prio");
        checks++;
        if (re_q.size() != base + 1 || re_q[$] !== 8'h50) begin
            errors++;
            $display("FAIL prio_a_wins: reads=%0d last=%h want 1/50", re_q.size() - base, re_q[$]);
        end
        jtag_op(0, 8'h10, 32'h0);
    endtask

    task automatic test_reset_mid;
        jtag_op(0, 8'h10, 32'h0);
        checks++;
        if (MonDReg !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL midrst_pre_mon: got %h want cafef00d", MonDReg);
        end
        jtag_strobe(0, 8'h60, 32'h0);
        tick();
        checks++;
        if (ram_re !== 1'b1) begin
            errors++;
            $display("FAIL midrst_in_rd: ram_re=%b want 1", ram_re);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ram_re !== 1'b0 || jtag_busy !== 1'b0 || MonDReg !== 32'h0 || ram_addr !== 8'h00) begin
            errors++;
            $display("FAIL midrst_abort: re=%b busy=%b mon=%h addr=%h want 0/0/0/00",
                     ram_re, jtag_busy, MonDReg, ram_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        jtag_op(1, 8'h0, 32'h0);
        checks++;
        if (re_q[$] !== 8'h00) begin
            errors++;
            $display("FAIL midrst_ptr: read addr %h want 00", re_q[$]);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd;
        logic [31:0] d;
        logic [7:0] a;
        int w;
        int kind;
        jtag_op(0, 8'h00, 32'h0);
        m_ptr = 8'h00;
        for (int i = 0; i < 256; i++) begin
            d = $urandom;
            jtag_op(2, 8'h0, d);
            model_mem[m_ptr] = d;
            m_ptr = m_ptr + 8'd1;
        end
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 4));
            a = 8'($urandom_range(0, 255));
            d = $urandom;
            case (kind)
                0: begin
                    jtag_op(0, a, 32'h0);
                    m_ptr = a;
                    checks++;
                    if (MonDReg !== model_mem[a]) begin
                        errors++;
                        $display("FAIL rnd_load_rd[%0d]: a=%h got %h want %h", i, a, MonDReg, model_mem[a]);
                    end
                end
                1: begin
                    jtag_op(1, 8'h0, 32'h0);
                    checks++;
                    if (MonDReg !== model_mem[m_ptr]) begin
                        errors++;
                        $display("FAIL rnd_rd_inc[%0d]: p=%h got %h want %h", i, m_ptr, MonDReg, model_mem[m_ptr]);
                    end
                    m_ptr = m_ptr + 8'd1;
                end
                2: begin
                    jtag_op(2, 8'h0, d);
                    model_mem[m_ptr] = d;
                    m_ptr = m_ptr + 8'd1;
                end
                3: begin
                    cpu_access(1'b1, a, d, rd, w);
                    model_mem[a] = d;
                    checks++;
                    if (w != 1) begin
                        errors++;
                        $display("FAIL rnd_cpu_wr[%0d]: wait=%0d want 1", i, w);
                    end
                end
                default: begin
                    cpu_access(1'b0, a, 32'h0, rd, w);
                    checks++;
                    if (w != 2 || rd !== model_mem[a]) begin
                        errors++;
                        $display("FAIL rnd_cpu_rd[%0d]: a=%h wait=%0d got %h want 2/%h", i, a, w, rd, model_mem[a]);
                    end
                end
            endcase
        end
        checks++;
        if (jtag_overrun !== 1'b0) begin
            errors++;
            $display("FAIL rnd_overrun: got %b want 0", jtag_overrun);
        end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_write_wrap();
        test_cpu_rw();
        test_tie();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
